gpu_warp_simt: RTL and testbench
================================

# gpu_warp_simt

Parametrised SIMT warp execution core: fetches 32-bit instructions from a local instruction memory and executes each on `NUM_THREADS` lanes in lockstep, under a per-warp thread mask. Each lane has its own 8-entry register file and its own flags. Sits under the scheduler: it is loaded through the imem write port, launched with `start`, and signals completion with `exit`.

## Interface
- `NUM_THREADS`, 4: lanes per warp (1..32)
- `DATA_W`, 32: lane datapath width (8..64, power of 2)
- `IMEM_DEPTH`, 16: instruction words; `PC_W = $clog2(IMEM_DEPTH)`

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  launch request, accepted only in IDLE
- `start_pc`  in  PC_W  first instruction address
- `thread_mask`  in  NUM_THREADS  active lanes, sampled with `start`
- `imem_we`  in  1  instruction write, honoured only in IDLE
- `imem_waddr`  in  PC_W  write address
- `imem_wdata`  in  32  instruction word
- `rd_lane`  in  $clog2(NUM_THREADS) (min 1)  debug-read lane
- `rd_reg`  in  3  debug-read register
- `rd_data`  out  DATA_W  registered debug-read data
- `busy`  out  1  warp running (FETCH/EXEC/DONE)
- `exit`  out  1  one-cycle completion pulse
- `fault`  out  1  sticky: PC ran past IMEM_DEPTH-1 without EXIT; cleared by the next accepted `start`
- `flags_z`, `flags_s`, `flags_c`, `flags_o`  out  NUM_THREADS each  per-lane flags

## Operation
- Instruction: [31:26] opcode, [25:23] rd, [22:20] rs1, [19:17] rs2, [16] imm_sel, [15:0] imm. Operand B = imm_sel ? zero-extended imm (truncated to DATA_W) : R[rs2].
- Opcodes: 0 ADD, 1 SUB, 2 MUL (low DATA_W bits), 3 AND, 4 OR, 5 XOR, 6 NAND, 7 NOR, 8 XNOR, 9 SHL, 10 SHR (logical), 11 ROL, 12 ROR, 13 LDI (rd = B), 14 EXIT, 15–63 NOP.
- Shift/rotate amount = B[$clog2(DATA_W)-1:0]. Amount 0 leaves the value unchanged.
- Flags, written only for active lanes and only by opcodes 0–13:
  - z = (result == 0); s = result MSB.
  - ADD: c = carry out. SUB: c = borrow (A < B unsigned).
  - o = signed overflow for ADD/SUB; c and o cleared by all other ALU ops and by LDI.
- Inactive lanes never write registers or flags. An all-zero mask still executes (no writes), then exits.
- Reset: all registers and flags are 0, except R7 of lane i = i; imem is not reset.
- FSM:
  - IDLE -> FETCH on `start`: latch PC and mask, clear `fault`.
  - FETCH: read imem[PC] into the instruction register. -> EXEC.
  - EXEC: compute and write back. On EXIT -> DONE. Else if PC == IMEM_DEPTH-1: set `fault` -> DONE. Else PC += 1 -> FETCH.
  - DONE: `exit` = 1 -> IDLE.
- `start` and `imem_we` outside IDLE are ignored.

## Timing
- All outputs are registered. Reset values: `rd_data` 0, `busy` 0, `exit` 0, `fault` 0, all flags 0.
- Each instruction takes 2 cycles. With `start` sampled at edge 0 and K instructions including EXIT:
  - EXIT is in EXEC during cycle 2K.
  - `exit` = 1 and `busy` = 1 during cycle 2K+1.
  - `busy` = 0 from cycle 2K+2.
- `imem_we` and `start` in the same IDLE cycle: the write lands first, so FETCH sees the new word.
- `rd_data` has 1-cycle latency and is valid in any state. A read of a register written in the same EXEC edge returns the new value one cycle later.
- `rst_n` asserted mid-run: immediate return to IDLE and all reset values restored; `exit` does not pulse.

## Configuration
- `GPU_WARP_MUL_EN` defined: opcode 2 = MUL.
- Undefined: opcode 2 decodes as NOP (no register or flag writes) and no multiplier is synthesised.

## Structure
- `gpu_warp_pkg`: opcode enum, instruction field positions, FSM state enum, `INSTR_W = 32`.
- Sub-module `gpu_lane_alu`: combinational per-lane ALU (A, B, opcode -> result, z/s/c/o), instantiated NUM_THREADS times via generate.

## Test plan
- Load LDI r1,#5; LDI r2,#3; ADD r3,r1,r2; EXIT at 0..3, start_pc 0, mask 4'b1111 -> every lane r3 = 8, z=0. `exit` pulses in cycle 9, `busy` falls at cycle 10.
- ADD r0,r7,#0xFFFF…(r7=lane id) with mask 4'b0101 -> lanes 0 and 2 get r0 = lane−1 (lane 0: 0xFFFFFFFF, s=1; lane 2: 1, c=1). Lanes 1 and 3 keep r0 = 0 and their flags unchanged.
- LDI r1,#0x8000; SHL r1,r1,#16; ADD r2,r1,r1 (DATA_W=32) -> r2 = 0, z=1, c=1, o=1.
- ROR of 0x00000001 by 1 -> 0x80000000, s=1. ROL by 0 -> value unchanged.
- Program with no EXIT starting at IMEM_DEPTH-2 -> `fault`=1 and `exit` pulse after 4 cycles. A following valid `start` clears `fault`.
- Assert `rst_n` during EXEC -> `busy`=0 immediately, no `exit` pulse, registers reset (r7 = lane id). `start` during a run is ignored (PC unaffected).

Source files
------------

// File: rtl/gpu_warp_pkg.sv
// Shared definitions for the SIMT warp core: instruction layout, opcodes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_warp_pkg;

  localparam int INSTR_W = 32;

  // Instruction field positions
  localparam int OPC_HI      = 31;
  localparam int OPC_LO      = 26;
  localparam int RD_HI       = 25;
  localparam int RD_LO       = 23;
  localparam int RS1_HI      = 22;
  localparam int RS1_LO      = 20;
  localparam int RS2_HI      = 19;
  localparam int RS2_LO      = 17;
  localparam int IMM_SEL_BIT = 16;
  localparam int IMM_HI      = 15;
  localparam int IMM_LO      = 0;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_MUL  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_NAND = 6'd6,
    OP_NOR  = 6'd7,
    OP_XNOR = 6'd8,
    OP_SHL  = 6'd9,
    OP_SHR  = 6'd10,
    OP_ROL  = 6'd11,
    OP_ROR  = 6'd12,
    OP_LDI  = 6'd13,
    OP_EXIT = 6'd14
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_e;

  // Packed view matching the field positions above, MSB first.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        imm_sel;
    logic [15:0] imm;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] word);
    return instr_t'(word);
  endfunction

endpackage

// File: rtl/gpu_lane_alu.sv
// Per-lane combinational ALU: result and z/s/c/o flags from A, B and opcode.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; wr_en tells the caller whether the opcode writes rd and flags.
// Ports: a, b (operands), opcode (6b), result, z/s/c/o flags, wr_en.
// Multiplier exists only when GPU_WARP_MUL_EN is defined; otherwise opcode 2 is a NOP.
module gpu_lane_alu
  import gpu_warp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              s,
  output logic              c,
  output logic              o,
  output logic              wr_en
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [SH_W-1:0]   amt;
  logic [SH_W:0]     amt_inv;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;

  assign amt  = b[SH_W-1:0];
  // Complementary rotate distance; at amt==0 this equals DATA_W and the
  // second shift term collapses to zero, leaving the value unchanged.
  assign amt_inv = (SH_W+1)'(DATA_W) - {1'b0, amt};
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  always_comb begin
    result = '0;
    c      = 1'b0;
    o      = 1'b0;
    wr_en  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        o      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        wr_en  = 1'b1;
      end
      OP_SUB: begin
        result = diff;
        c      = (a < b);
        o      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        wr_en  = 1'b1;
      end
`ifdef GPU_WARP_MUL_EN
      OP_MUL: begin
        result = a * b;
        wr_en  = 1'b1;
      end
`endif
      OP_AND:  begin result = a & b;    wr_en = 1'b1; end
      OP_OR:   begin result = a | b;    wr_en = 1'b1; end
      OP_XOR:  begin result = a ^ b;    wr_en = 1'b1; end
      OP_NAND: begin result = ~(a & b); wr_en = 1'b1; end
      OP_NOR:  begin result = ~(a | b); wr_en = 1'b1; end
      OP_XNOR: begin result = ~(a ^ b); wr_en = 1'b1; end
      OP_SHL:  begin result = a << amt; wr_en = 1'b1; end
      OP_SHR:  begin result = a >> amt; wr_en = 1'b1; end
      OP_ROL:  begin result = (a << amt) | (a >> amt_inv); wr_en = 1'b1; end
      OP_ROR:  begin result = (a >> amt) | (a << amt_inv); wr_en = 1'b1; end
      OP_LDI:  begin result = b;        wr_en = 1'b1; end
      default: ;
    endcase
  end

  assign z = (result == '0);
  assign s = result[MSB];

endmodule

// File: rtl/gpu_warp_simt.sv
// SIMT warp core: fetches 32-bit instructions from local imem, executes on NUM_THREADS lanes under a mask.
// Latency: 2 cycles per instruction (FETCH, EXEC), plus one DONE cycle carrying the exit pulse.
// Backpressure: none; start and imem_we are only honoured in IDLE and silently dropped otherwise.
// Ports: clk, rst_n (async, active low); imem_we/imem_waddr/imem_wdata load port; start/start_pc/
//   thread_mask launch; rd_lane/rd_reg -> rd_data registered debug read; busy, exit (pulse),
//   fault (sticky, PC ran off the end), per-lane flags_z/s/c/o.
// Optional feature macro: GPU_WARP_MUL_EN (enables opcode 2 = MUL; otherwise it is a NOP).
module gpu_warp_simt
  import gpu_warp_pkg::*;
#(
  parameter  int NUM_THREADS = 4,
  parameter  int DATA_W      = 32,
  parameter  int IMEM_DEPTH  = 16,
  localparam int PC_W        = $clog2(IMEM_DEPTH),
  localparam int LANE_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PC_W-1:0]        start_pc,
  input  logic [NUM_THREADS-1:0] thread_mask,
  input  logic                   imem_we,
  input  logic [PC_W-1:0]        imem_waddr,
  input  logic [INSTR_W-1:0]     imem_wdata,
  input  logic [LANE_W-1:0]      rd_lane,
  input  logic [2:0]             rd_reg,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   busy,
  output logic                   exit,
  output logic                   fault,
  output logic [NUM_THREADS-1:0] flags_z,
  output logic [NUM_THREADS-1:0] flags_s,
  output logic [NUM_THREADS-1:0] flags_c,
  output logic [NUM_THREADS-1:0] flags_o
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);

  state_e                 state;
  logic [PC_W-1:0]        pc;
  logic [NUM_THREADS-1:0] warp_mask;
  instr_t                 ir;

  logic [INSTR_W-1:0]     imem [IMEM_DEPTH];
  logic [DATA_W-1:0]      regs [NUM_THREADS][8];

  logic [DATA_W-1:0]                   imm_ext;
  logic [NUM_THREADS-1:0][DATA_W-1:0]  alu_res;
  logic [NUM_THREADS-1:0]              alu_z;
  logic [NUM_THREADS-1:0]              alu_s;
  logic [NUM_THREADS-1:0]              alu_c;
  logic [NUM_THREADS-1:0]              alu_o;
  logic [NUM_THREADS-1:0]              alu_we;

  // Instruction memory: not reset; writes only land while idle so a running
  // program cannot be modified underneath itself.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Control FSM. busy/exit are registered alongside the state transition so
  // they line up exactly with the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      warp_mask <= '0;
      ir        <= '0;
      busy      <= 1'b0;
      exit      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      exit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            pc        <= start_pc;
            warp_mask <= thread_mask;
            fault     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= decode(imem[pc]);
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (ir.opcode == OP_EXIT) begin
            state <= S_DONE;
            exit  <= 1'b1;
          end else if (pc == LAST_PC) begin
            fault <= 1'b1;
            state <= S_DONE;
            exit  <= 1'b1;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Immediate is zero-extended, or truncated for narrow datapaths.
  if (DATA_W > 16) begin : g_imm_wide
    assign imm_ext = {{(DATA_W-16){1'b0}}, ir.imm};
  end else begin : g_imm_narrow
    assign imm_ext = ir.imm[DATA_W-1:0];
  end

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_lane
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign op_a = regs[g][ir.rs1];
    assign op_b = ir.imm_sel ? imm_ext : regs[g][ir.rs2];

    gpu_lane_alu #(
      .DATA_W (DATA_W)
    ) u_alu (
      .a      (op_a),
      .b      (op_b),
      .opcode (ir.opcode),
      .result (alu_res[g]),
      .z      (alu_z[g]),
      .s      (alu_s[g]),
      .c      (alu_c[g]),
      .o      (alu_o[g]),
      .wr_en  (alu_we[g])
    );
  end

  // Register files and flags. R7 of each lane resets to its lane index so
  // programs can derive per-lane values without extra inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_THREADS; l++) begin
        for (int r = 0; r < 8; r++) begin
          regs[l][r] <= (r == 7) ? DATA_W'(l) : '0;
        end
      end
      flags_z <= '0;
      flags_s <= '0;
      flags_c <= '0;
      flags_o <= '0;
    end else if (state == S_EXEC) begin
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (warp_mask[l] && alu_we[l]) begin
          regs[l][ir.rd] <= alu_res[l];
          flags_z[l]     <= alu_z[l];
          flags_s[l]     <= alu_s[l];
          flags_c[l]     <= alu_c[l];
          flags_o[l]     <= alu_o[l];
        end
      end
    end
  end

  // Debug read port, one cycle latency, usable in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (32'(rd_lane) < NUM_THREADS) begin
      rd_data <= regs[rd_lane][rd_reg];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_gpu_warp_simt.sv
module tb_gpu_warp_simt;

  localparam int NT  = 4;
  localparam int DW  = 32;
  localparam int PCW = 4;
  localparam int LW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [PCW-1:0]  start_pc = '0;
  logic [NT-1:0]   thread_mask = '0;
  logic            imem_we = 1'b0;
  logic [PCW-1:0]  imem_waddr = '0;
  logic [31:0]     imem_wdata = '0;
  logic [LW-1:0]   rd_lane = '0;
  logic [2:0]      rd_reg = '0;
  logic [DW-1:0]   rd_data;
  logic            busy;
  logic            dut_exit;
  logic            fault;
  logic [NT-1:0]   fz, fs, fc, fo;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  gpu_warp_simt #(.NUM_THREADS(NT), .DATA_W(DW), .IMEM_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .thread_mask(thread_mask),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .rd_lane(rd_lane), .rd_reg(rd_reg), .rd_data(rd_data),
    .busy(busy), .exit(dut_exit), .fault(fault),
    .flags_z(fz), .flags_s(fs), .flags_c(fc), .flags_o(fo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string           name;
    logic [3:0][31:0] prog;
    int              n;
    logic [NT-1:0]   mask;
    int              chk_reg;
    logic [3:0][31:0] exp_val;
    logic [NT-1:0]   ez, es, ec, eo;
  } vec_t;

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2,
                                      input bit isel, input int imm);
    return {6'(op), 3'(rd), 3'(rs1), 3'(rs2), isel, 16'(imm)};
  endfunction
  function automatic logic [31:0] ldi(input int rd, input int imm);
    return enc(13, rd, 0, 0, 1'b1, imm);
  endfunction
  function automatic logic [31:0] alui(input int op, input int rd, input int rs1, input int imm);
    return enc(op, rd, rs1, 0, 1'b1, imm);
  endfunction
  function automatic logic [31:0] alur(input int op, input int rd, input int rs1, input int rs2);
    return enc(op, rd, rs1, rs2, 1'b0, 0);
  endfunction

  function automatic vec_t mkv(input string nm, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] i2, input logic [31:0] i3, input int n,
                               input logic [NT-1:0] m, input int r,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3,
                               input logic [NT-1:0] z, input logic [NT-1:0] s,
                               input logic [NT-1:0] c, input logic [NT-1:0] o);
    vec_t t;
    t.name = nm; t.prog[0] = i0; t.prog[1] = i1; t.prog[2] = i2; t.prog[3] = i3;
    t.n = n; t.mask = m; t.chk_reg = r;
    t.exp_val[0] = e0; t.exp_val[1] = e1; t.exp_val[2] = e2; t.exp_val[3] = e3;
    t.ez = z; t.es = s; t.ec = c; t.eo = o;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); rst_n = 1'b0; start = 1'b0; imem_we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Scoreboard read: expectation queued with the request, popped when rd_data is due.
  task automatic rd_check(input int lane, input int r, input logic [31:0] e, input string nm);
    logic [31:0] want;
    @(negedge clk); rd_lane = LW'(lane); rd_reg = 3'(r); exp_q.push_back(e);
    @(negedge clk); want = exp_q.pop_front();
    chk(nm, rd_data, want);
  endtask

  // Loads words 1..n-1, then writes word 0 in the same cycle as start.
  // Returns #1 after the start-sampling edge (edge 0).
  task automatic launch(input vec_t t, input logic [PCW-1:0] pc0);
    for (int i = 1; i < t.n; i++) begin
      @(negedge clk); imem_we = 1'b1; imem_waddr = pc0 + PCW'(i); imem_wdata = t.prog[i];
    end
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = pc0; imem_wdata = t.prog[0];
    start = 1'b1; start_pc = pc0; thread_mask = t.mask;
    @(posedge clk); #1;
    imem_we = 1'b0; start = 1'b0;
  endtask

  // Cycle c is the period ending at edge c; sampled on the negedge inside it.
  task automatic wait_exit(input int exp_c, input int first_c, input string nm);
    int got;
    got = -1;
    for (int c = first_c; c <= first_c + 60; c++) begin
      @(negedge clk);
      if (got < 0 && dut_exit) begin
        got = c;
        chk({nm, "_busy_at_exit"}, busy, 1);
      end else if (got >= 0) begin
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_exit_one_cycle"}, dut_exit, 0);
        break;
      end
    end
    chk({nm, "_exit_cycle"}, got, exp_c);
  endtask

  vec_t v[12];
  vec_t h;
  logic [31:0] ew;
  logic [31:0] nopw;
  int exits;

  initial begin
    ew   = enc(14, 0, 0, 0, 1'b0, 0);
    nopw = enc(15, 0, 0, 0, 1'b0, 0);

    v[0]  = mkv("add", ldi(1,5), ldi(2,3), alur(0,3,1,2), ew, 4, 4'hF, 3,
                8, 8, 8, 8, 4'h0, 4'h0, 4'h0, 4'h0);
    v[1]  = mkv("mask", alur(7,1,0,0), alur(0,0,7,1), ew, ew, 3, 4'b0101, 0,
                32'hFFFFFFFF, 0, 1, 0, 4'h0, 4'b0001, 4'b0100, 4'h0);
    v[2]  = mkv("ovf", ldi(1,16'h8000), alui(9,1,1,16), alur(0,2,1,1), ew, 4, 4'hF, 2,
                0, 0, 0, 0, 4'hF, 4'h0, 4'hF, 4'hF);
    v[3]  = mkv("rot", ldi(1,1), alui(12,2,1,1), alui(11,3,2,0), ew, 4, 4'hF, 3,
                32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 4'h0, 4'hF, 4'h0, 4'h0);
    v[4]  = mkv("sub_borrow", ldi(1,3), alui(1,2,1,5), ew, ew, 3, 4'hF, 2,
                32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 4'h0, 4'hF, 4'hF, 4'h0);
    v[5]  = mkv("sub_lane", alui(1,0,7,1), ew, ew, ew, 2, 4'hF, 0,
                32'hFFFFFFFF, 0, 1, 2, 4'b0010, 4'b0001, 4'b0001, 4'h0);
    v[6]  = mkv("nand", ldi(1,16'h00F0), alui(6,2,1,16'h00FF), ew, ew, 3, 4'hF, 2,
                32'hFFFFFF0F, 32'hFFFFFF0F, 32'hFFFFFF0F, 32'hFFFFFF0F, 4'h0, 4'hF, 4'h0, 4'h0);
    v[7]  = mkv("shr_amt", ldi(1,16'h8000), alui(10,2,1,35), ew, ew, 3, 4'hF, 2,
                32'h1000, 32'h1000, 32'h1000, 32'h1000, 4'h0, 4'h0, 4'h0, 4'h0);
`ifdef GPU_WARP_MUL_EN
    v[8]  = mkv("mul", ldi(1,7), alui(1,2,1,8), alui(2,1,1,6), ew, 4, 4'hF, 1,
                42, 42, 42, 42, 4'h0, 4'h0, 4'h0, 4'h0);
`else
    v[8]  = mkv("mul_nop", ldi(1,7), alui(1,2,1,8), alui(2,1,1,6), ew, 4, 4'hF, 1,
                7, 7, 7, 7, 4'h0, 4'hF, 4'hF, 4'h0);
`endif
    v[9]  = mkv("zero_mask", ldi(1,9), ew, ew, ew, 2, 4'h0, 1,
                0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    v[10] = mkv("and_or", ldi(1,16'h0F0F), alui(4,2,1,16'hF000), alur(3,3,2,7), ew, 4, 4'hF, 3,
                0, 1, 2, 3, 4'b0001, 4'h0, 4'h0, 4'h0);
    v[11] = mkv("xnor", ldi(1,16'h00FF), alui(5,2,1,16'h0F0F), alur(8,3,2,7), ew, 4, 4'hF, 3,
                32'hFFFFF00F, 32'hFFFFF00E, 32'hFFFFF00D, 32'hFFFFF00C, 4'h0, 4'hF, 4'h0, 4'h0);

    // Reset values while rst_n is held low
    @(negedge clk);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exit", dut_exit, 0);
    chk("rst_fault", fault, 0);
    chk("rst_flags", {fz, fs, fc, fo}, 0);
    rst_n = 1'b1;
    for (int l = 0; l < NT; l++) rd_check(l, 7, l, $sformatf("rst_r7_lane%0d", l));

    // Table-driven programs, each from a fresh reset
    foreach (v[i]) begin
      reset_dut();
      launch(v[i], '0);
      wait_exit(2 * v[i].n + 1, 1, v[i].name);
      chk({v[i].name, "_fz"}, fz, v[i].ez);
      chk({v[i].name, "_fs"}, fs, v[i].es);
      chk({v[i].name, "_fc"}, fc, v[i].ec);
      chk({v[i].name, "_fo"}, fo, v[i].eo);
      chk({v[i].name, "_fault"}, fault, 0);
      for (int l = 0; l < NT; l++)
        rd_check(l, v[i].chk_reg, v[i].exp_val[l], $sformatf("%s_r%0d_lane%0d", v[i].name, v[i].chk_reg, l));
    end

    // PC runs off the end without EXIT
    reset_dut();
    h = mkv("fault", nopw, nopw, 0, 0, 2, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    launch(h, 4'd14);
    wait_exit(5, 1, "fault_run");
    chk("fault_sticky", fault, 1);
    h = mkv("fault_clr", ew, 0, 0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    launch(h, 4'd0);
    chk("fault_cleared_by_start", fault, 0);
    wait_exit(3, 1, "fault_clr_run");

    // Asynchronous reset during EXEC, plus read-after-write timing
    reset_dut();
    rd_lane = 2'd1; rd_reg = 3'd7;
    h = mkv("rst_mid", ldi(7,16'h55), ldi(2,6), ew, 0, 3, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    launch(h, 4'd0);
    @(negedge clk); @(negedge clk);
    @(negedge clk);
    chk("raw_old_value", rd_data, 1);
    @(negedge clk);
    chk("raw_new_value", rd_data, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_exit", dut_exit, 0);
    chk("rst_mid_rd_data", rd_data, 0);
    @(negedge clk); rst_n = 1'b1;
    exits = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dut_exit) exits++;
    end
    chk("rst_mid_no_exit", exits, 0);
    chk("rst_mid_idle", busy, 0);
    rd_check(1, 7, 1, "rst_mid_r7_lane1");
    rd_check(3, 7, 3, "rst_mid_r7_lane3");
    rd_check(0, 2, 0, "rst_mid_r2_lane0");

    // start and imem_we during a run are ignored
    reset_dut();
    h = mkv("ignore", ldi(1,1), ldi(1,2), ew, 0, 3, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    launch(h, 4'd0);
    @(negedge clk); @(negedge clk);
    @(negedge clk);
    start = 1'b1; start_pc = 4'd8; thread_mask = 4'h0;
    imem_we = 1'b1; imem_waddr = 4'd2; imem_wdata = ldi(1, 99);
    @(negedge clk);
    start = 1'b0; imem_we = 1'b0;
    wait_exit(7, 5, "ignore_run");
    rd_check(2, 1, 2, "ignore_r1_lane2");
    rd_check(0, 1, 2, "ignore_r1_lane0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
